// File: rtl/l2_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_cmd_sched_if
// Purpose  : Bundles the requester handshake, the L3 engine/watchdog
//            signals and the completion status for l2_cmd_sched.
// Modports : master - environment side (requesters, L3 engine, watchdog, SW)
//            slave  - scheduler side (l2_cmd_sched)
// Signals  : req0/cmd0/gnt0, req1/cmd1/gnt1  requester handshakes
//            l3_en/l3_cmd                    engine start pulse + command
//            l3_cmd_done/err_timeout/abort   completion events
//            timer_stop                      watchdog stop on abort
//            done_vld/done_src/done_err      completion status pulse
//            retry_cnt/busy                  scheduler status
// Revision : 1.0 - initial release
// ============================================================================
interface l2_cmd_sched_if #(
  parameter int CMD_W = 8
);
  logic             req0;
  logic [CMD_W-1:0] cmd0;
  logic             gnt0;
  logic             req1;
  logic [CMD_W-1:0] cmd1;
  logic             gnt1;
  logic             l3_en;
  logic [CMD_W-1:0] l3_cmd;
  logic             l3_cmd_done;
  logic             err_timeout;
  logic             abort;
  logic             timer_stop;
  logic             done_vld;
  logic             done_src;
  logic             done_err;
  logic [1:0]       retry_cnt;
  logic             busy;

  modport master (
    output req0, cmd0, req1, cmd1, l3_cmd_done, err_timeout, abort,
    input  gnt0, gnt1, l3_en, l3_cmd, timer_stop, done_vld, done_src,
           done_err, retry_cnt, busy
  );

  modport slave (
    input  req0, cmd0, req1, cmd1, l3_cmd_done, err_timeout, abort,
    output gnt0, gnt1, l3_en, l3_cmd, timer_stop, done_vld, done_src,
           done_err, retry_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/l2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : l2_cmd_sched
// Purpose  : Two-requester scheduler in front of the L3 command engine.
//            Arbitrates requests, issues the one-cycle l3_en start pulse
//            (which also arms the watchdog), re-issues on watchdog timeout
//            up to MAX_RETRY times, handles software abort, reports a
//            completion pulse to the originator and enforces an idle gap.
// Ports    : clk, rst_n (async, active-low), bus (l2_cmd_sched_if.slave)
// Params   : CMD_W     - command word width
//            MAX_RETRY - re-issues allowed after timeout (0..3)
//            GAP_CYC   - idle cycles after each completion (0..15)
// Macro    : L2_CMD_SCHED_STRICT_PRIO_EN - when defined, requester 0 always
//            wins a tie; otherwise ties are resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cmd_sched #(
  parameter int CMD_W     = 8,
  parameter int MAX_RETRY = 2,
  parameter int GAP_CYC   = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  l2_cmd_sched_if.slave bus
);

  localparam logic [1:0] c_MAX_RETRY = 2'(MAX_RETRY);
  localparam logic [3:0] c_GAP_LAST  = 4'(GAP_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_gap;
  logic             r_src;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_l3_en;
  logic [CMD_W-1:0] r_l3_cmd;
  logic             r_timer_stop;
  logic             r_done_vld;
  logic             r_done_src;
  logic             r_done_err;
  logic [1:0]       r_retry;
  logic             r_busy;
`ifndef L2_CMD_SCHED_STRICT_PRIO_EN
  logic             r_last_src;
`endif

  logic w_req_any;
  logic w_pick1;

  // Arbitration: w_pick1 selects requester 1 for the grant.
  always_comb begin
    w_req_any = bus.req0 | bus.req1;
`ifdef L2_CMD_SCHED_STRICT_PRIO_EN
    w_pick1   = bus.req1 & ~bus.req0;
`else
    // On a tie the requester that was not served last wins.
    w_pick1   = bus.req1 & (~bus.req0 | ~r_last_src);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gap        <= 4'd0;
      r_src        <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_l3_en      <= 1'b0;
      r_l3_cmd     <= '0;
      r_timer_stop <= 1'b0;
      r_done_vld   <= 1'b0;
      r_done_src   <= 1'b0;
      r_done_err   <= 1'b0;
      r_retry      <= 2'd0;
      r_busy       <= 1'b0;
`ifndef L2_CMD_SCHED_STRICT_PRIO_EN
      r_last_src   <= 1'b1;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_l3_en      <= 1'b0;
      r_timer_stop <= 1'b0;
      r_done_vld   <= 1'b0;
      r_done_src   <= 1'b0;
      r_done_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_gnt0   <= ~w_pick1;
            r_gnt1   <= w_pick1;
            r_l3_cmd <= w_pick1 ? bus.cmd1 : bus.cmd0;
            r_src    <= w_pick1;
`ifndef L2_CMD_SCHED_STRICT_PRIO_EN
            r_last_src <= w_pick1;
`endif
            r_retry  <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          r_l3_en <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion beats abort, abort beats timeout.
          if (bus.l3_cmd_done) begin
            r_done_vld <= 1'b1;
            r_done_src <= r_src;
            r_gap      <= 4'd0;
            r_state    <= ST_GAP;
          end else if (bus.abort) begin
            r_timer_stop <= 1'b1;
            r_done_vld   <= 1'b1;
            r_done_src   <= r_src;
            r_done_err   <= 1'b1;
            r_gap        <= 4'd0;
            r_state      <= ST_GAP;
          end else if (bus.err_timeout) begin
            if (r_retry < c_MAX_RETRY) begin
              r_retry <= r_retry + 2'd1;
              r_state <= ST_START;
            end else begin
              r_done_vld <= 1'b1;
              r_done_src <= r_src;
              r_done_err <= 1'b1;
              r_gap      <= 4'd0;
              r_state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0       = r_gnt0;
  assign bus.gnt1       = r_gnt1;
  assign bus.l3_en      = r_l3_en;
  assign bus.l3_cmd     = r_l3_cmd;
  assign bus.timer_stop = r_timer_stop;
  assign bus.done_vld   = r_done_vld;
  assign bus.done_src   = r_done_src;
  assign bus.done_err   = r_done_err;
  assign bus.retry_cnt  = r_retry;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_l2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_cmd_sched
// Purpose  : Self-checking bench for l2_cmd_sched (CMD_W=8, MAX_RETRY=2,
//            GAP_CYC=4). Cycle-table vectors plus directed sequences for
//            tie arbitration, retry, abort, simultaneous events and reset.
//            Honours L2_CMD_SCHED_STRICT_PRIO_EN for tie expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cmd_sched;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  l2_cmd_sched_if #(.CMD_W(8)) bus ();

  l2_cmd_sched #(
    .CMD_W     (8),
    .MAX_RETRY (2),
    .GAP_CYC   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: time limit reached before summary");
    $fatal(1, "simulation time limit");
  end

  // Row: {req1,req0}, cmd0, cmd1, {done,tmo,abort} applied before an edge;
  // expected after it: {gnt0,gnt1,l3_en}, l3_cmd,
  // {timer_stop,done_vld,done_src,done_err}, retry_cnt, busy.
  typedef struct {
    logic [1:0] req;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [2:0] ev;
    logic [2:0] g;
    logic [7:0] cmd;
    logic [3:0] s;
    logic [1:0] rc;
    logic       bz;
  } vec_t;

  vec_t vec [23];

  function automatic logic [17:0] outs();
    return {bus.gnt0, bus.gnt1, bus.l3_en, bus.l3_cmd, bus.timer_stop,
            bus.done_vld, bus.done_src, bus.done_err, bus.retry_cnt, bus.busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.cmd0 = 8'h00;
    bus.req1 = 1'b0; bus.cmd1 = 8'h00;
    bus.l3_cmd_done = 1'b0; bus.err_timeout = 1'b0; bus.abort = 1'b0;
  endtask

  // Raise one request, wait (bounded) for its grant, then drop it.
  task automatic grant(input logic src, input logic [7:0] cmd);
    bit got;
    got = 1'b0;
    if (src) begin bus.req1 = 1'b1; bus.cmd1 = cmd; end
    else     begin bus.req0 = 1'b1; bus.cmd0 = cmd; end
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (bus.gnt0 || bus.gnt1) got = 1'b1;
    end
    chk("grant_src", {30'd0, bus.gnt1, bus.gnt0}, src ? 32'd2 : 32'd1);
    chk("grant_cmd", {24'd0, bus.l3_cmd}, {24'd0, cmd});
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && bus.busy; n++) tick();
    chk("drain_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  int   en_cnt;
  int   both_hi;
  int   spur;
  bit   got;
  logic exp1;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();

    //                req    c0     c1     ev      g       cmd    s        rc    bz
    vec[0]  = '{2'b01, 8'hA5, 8'h00, 3'b000, 3'b100, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[1]  = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b001, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[2]  = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[3]  = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[4]  = '{2'b00, 8'h00, 8'h00, 3'b100, 3'b000, 8'hA5, 4'b0100, 2'd0, 1'b1};
    vec[5]  = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[6]  = '{2'b00, 8'h00, 8'h00, 3'b100, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[7]  = '{2'b10, 8'h00, 8'h3C, 3'b001, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[8]  = '{2'b10, 8'h00, 8'h3C, 3'b010, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b1};
    vec[9]  = '{2'b10, 8'h00, 8'h3C, 3'b000, 3'b000, 8'hA5, 4'b0000, 2'd0, 1'b0};
    vec[10] = '{2'b10, 8'h00, 8'h3C, 3'b000, 3'b010, 8'h3C, 4'b0000, 2'd0, 1'b1};
    vec[11] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b001, 8'h3C, 4'b0000, 2'd0, 1'b1};
    vec[12] = '{2'b00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h3C, 4'b0000, 2'd1, 1'b1};
    vec[13] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b001, 8'h3C, 4'b0000, 2'd1, 1'b1};
    vec[14] = '{2'b00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[15] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b001, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[16] = '{2'b00, 8'h00, 8'h00, 3'b010, 3'b000, 8'h3C, 4'b0111, 2'd2, 1'b1};
    vec[17] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[18] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[19] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[20] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b1};
    vec[21] = '{2'b00, 8'h00, 8'h00, 3'b000, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b0};
    vec[22] = '{2'b00, 8'h00, 8'h00, 3'b001, 3'b000, 8'h3C, 4'b0000, 2'd2, 1'b0};

    // Reset state
    #12;
    chk("reset_outputs", {14'd0, outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single request, ignored events in GAP, request held over GAP,
    // retry exhaustion, abort in IDLE.
    for (int i = 0; i < 23; i++) begin
      bus.req0 = vec[i].req[0]; bus.cmd0 = vec[i].c0;
      bus.req1 = vec[i].req[1]; bus.cmd1 = vec[i].c1;
      bus.l3_cmd_done = vec[i].ev[2];
      bus.err_timeout = vec[i].ev[1];
      bus.abort       = vec[i].ev[0];
      tick();
      chk($sformatf("vec%0d", i), {14'd0, outs()},
          {14'd0, vec[i].g, vec[i].cmd, vec[i].s, vec[i].rc, vec[i].bz});
    end
    clear_inputs();

    // Tie arbitration: both requests held over four commands.
    both_hi = 0;
    bus.req0 = 1'b1; bus.cmd0 = 8'h11;
    bus.req1 = 1'b1; bus.cmd1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        tick();
        if (bus.gnt0 && bus.gnt1) both_hi++;
        if (bus.gnt0 || bus.gnt1) got = 1'b1;
      end
`ifdef L2_CMD_SCHED_STRICT_PRIO_EN
      exp1 = 1'b0;
`else
      exp1 = k[0];
`endif
      chk($sformatf("tie%0d_src", k), {30'd0, bus.gnt1, bus.gnt0}, exp1 ? 32'd2 : 32'd1);
      chk($sformatf("tie%0d_cmd", k), {24'd0, bus.l3_cmd}, exp1 ? 32'h22 : 32'h11);
      tick();
      tick();
      bus.l3_cmd_done = 1'b1;
      tick();
      bus.l3_cmd_done = 1'b0;
      drain();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("gnt_exclusive", both_hi, 32'd0);

    // Two timeouts, then completion without error.
    grant(1'b0, 8'h5A);
    tick();
    en_cnt = bus.l3_en ? 1 : 0;
    for (int t = 0; t < 2; t++) begin
      bus.err_timeout = 1'b1;
      tick();
      bus.err_timeout = 1'b0;
      chk($sformatf("retry_cnt%0d", t), {30'd0, bus.retry_cnt}, t + 1);
      tick();
      if (bus.l3_en) en_cnt++;
    end
    chk("retry_en_pulses", en_cnt, 32'd3);
    chk("retry_l3_cmd", {24'd0, bus.l3_cmd}, 32'h5A);
    bus.l3_cmd_done = 1'b1;
    tick();
    bus.l3_cmd_done = 1'b0;
    chk("retry_done", {28'd0, bus.done_vld, bus.done_err, bus.retry_cnt}, 32'b1010);
    drain();

    // Done, abort and timeout in the same WAIT cycle: completion wins.
    grant(1'b0, 8'h77);
    tick();
    bus.l3_cmd_done = 1'b1; bus.abort = 1'b1; bus.err_timeout = 1'b1;
    tick();
    clear_inputs();
    chk("simul_events", {27'd0, bus.done_vld, bus.done_err, bus.timer_stop, bus.retry_cnt},
        32'b10000);
    drain();

    // Abort in START is ignored; abort in WAIT ends with error.
    grant(1'b1, 8'h99);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_in_start", {29'd0, bus.l3_en, bus.timer_stop, bus.done_vld}, 32'b100);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_in_wait", {28'd0, bus.timer_stop, bus.done_vld, bus.done_err, bus.done_src},
        32'b1111);
    drain();

    // Reset during WAIT with req1 pending.
    grant(1'b0, 8'hC3);
    tick();
    tick();
    bus.req1 = 1'b1; bus.cmd1 = 8'hE7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_cmd", {14'd0, outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    got  = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (bus.done_vld) spur++;
      if (bus.gnt0 || bus.gnt1) got = 1'b1;
    end
    chk("post_reset_grant", {22'd0, bus.gnt1, bus.gnt0, bus.l3_cmd}, {22'd0, 2'b10, 8'hE7});
    chk("post_reset_no_done", spur, 32'd0);
    bus.req1 = 1'b0;
    tick();
    chk("post_reset_en", {31'd0, bus.l3_en}, 32'd1);
    bus.l3_cmd_done = 1'b1;
    tick();
    bus.l3_cmd_done = 1'b0;
    chk("post_reset_done", {29'd0, bus.done_vld, bus.done_src, bus.done_err}, 32'b110);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
